// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: PC > round-robin(ALU, load) into one registered
// write port, plus a per-register pending-write scoreboard for decode hazard checks.
module reg_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              pc_valid,
  input  logic [DATA_W-1:0] pc_data,
  output logic              pc_ready,

  input  logic              alu_valid,
  input  logic [2:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,

  input  logic              mem_valid,
  input  logic [2:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,

  input  logic              issue_valid,
  input  logic [2:0]        issue_rd,
  input  logic [2:0]        rs_a,
  input  logic [2:0]        rs_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [NREG-1:0]   busy,

  output logic              WE_R,
  output logic [3:0]        WrReg_Rd,
  output logic [DATA_W-1:0] InData_R
);

  localparam logic [2:0] PC_REG = 3'd7;

  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_MEM = 1'b1
  } arb_state_t;

  arb_state_t        state;
  logic              grant_pc;
  logic              grant_alu;
  logic              grant_mem;
  logic              grant_any;
  logic [2:0]        grant_rd;
  logic [DATA_W-1:0] grant_data;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  function automatic logic [NREG-1:0] reg_decode(input logic [2:0] r);
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++)
      if (r == 3'(i)) m[i] = 1'b1;
    return m;
  endfunction

  // Grants are gated by rst_n so no handshake completes while reset is held.
  always_comb begin
    grant_pc  = rst_n & pc_valid;
    grant_alu = rst_n & ~pc_valid & alu_valid & (~mem_valid | (state == PREF_ALU));
    grant_mem = rst_n & ~pc_valid & mem_valid & (~alu_valid | (state == PREF_MEM));
    grant_any = grant_pc | grant_alu | grant_mem;
  end

  assign pc_ready  = grant_pc;
  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_rd   = '0;
    grant_data = '0;
    if (grant_pc) begin
      grant_rd   = PC_REG;
      grant_data = pc_data;
    end else if (grant_alu) begin
      grant_rd   = alu_rd;
      grant_data = alu_data;
    end else if (grant_mem) begin
      grant_rd   = mem_rd;
      grant_data = mem_data;
    end
  end

  always_comb begin
    set_mask = issue_valid ? reg_decode(issue_rd) : '0;
    clr_mask = grant_any   ? reg_decode(grant_rd) : '0;
  end

  assign hazard_a = |(busy & reg_decode(rs_a));
  assign hazard_b = |(busy & reg_decode(rs_b));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PREF_ALU;
      busy     <= '0;
      WE_R     <= 1'b0;
      WrReg_Rd <= '0;
      InData_R <= '0;
    end else begin
      if (grant_alu)
        state <= PREF_MEM;
      else if (grant_mem)
        state <= PREF_ALU;

      // Set is applied after clear so an issue to the register being written keeps it busy.
      busy <= (busy & ~clr_mask) | set_mask;

      WE_R <= grant_any;
      if (grant_any) begin
        WrReg_Rd <= {1'b0, grant_rd};
        InData_R <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus random traffic,
// all compared against a transaction-level model of grants, write port and scoreboard.
module tb_reg_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pc_valid = 1'b0;
  logic [DATA_W-1:0] pc_data = '0;
  logic              pc_ready;
  logic              alu_valid = 1'b0;
  logic [2:0]        alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [2:0]        mem_rd = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic              issue_valid = 1'b0;
  logic [2:0]        issue_rd = '0;
  logic [2:0]        rs_a = '0;
  logic [2:0]        rs_b = '0;
  logic              hazard_a;
  logic              hazard_b;
  logic [NREG-1:0]   busy;
  logic              WE_R;
  logic [3:0]        WrReg_Rd;
  logic [DATA_W-1:0] InData_R;

  reg_wb_arbiter #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_valid(pc_valid), .pc_data(pc_data), .pc_ready(pc_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs_a(rs_a), .rs_b(rs_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy),
    .WE_R(WE_R), .WrReg_Rd(WrReg_Rd), .InData_R(InData_R)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who gets the port, and what the register file sees next cycle.
  bit                m_pref_mem;
  logic [NREG-1:0]   m_busy;
  logic              m_we;
  logic [3:0]        m_rd;
  logic [DATA_W-1:0] m_data;

  localparam int G_NONE = 0, G_PC = 1, G_ALU = 2, G_MEM = 3;

  function automatic int pick();
    if (pc_valid)              return G_PC;
    if (alu_valid && mem_valid) return m_pref_mem ? G_MEM : G_ALU;
    if (alu_valid)             return G_ALU;
    if (mem_valid)             return G_MEM;
    return G_NONE;
  endfunction

  task automatic model_reset();
    m_pref_mem = 1'b0;
    m_busy     = '0;
    m_we       = 1'b0;
    m_rd       = '0;
    m_data     = '0;
  endtask

  task automatic clear_inputs();
    pc_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int g;
    #1;
    g = pick();
    check("pc_ready",  pc_ready,  g == G_PC);
    check("alu_ready", alu_ready, g == G_ALU);
    check("mem_ready", mem_ready, g == G_MEM);
    check("hazard_a",  hazard_a,  m_busy[rs_a]);
    check("hazard_b",  hazard_b,  m_busy[rs_b]);
    @(posedge clk);
    m_we = (g != G_NONE);
    case (g)
      G_PC:  begin m_rd = 4'd7;           m_data = pc_data;  end
      G_ALU: begin m_rd = {1'b0, alu_rd}; m_data = alu_data; m_pref_mem = 1'b1; end
      G_MEM: begin m_rd = {1'b0, mem_rd}; m_data = mem_data; m_pref_mem = 1'b0; end
      default: ;
    endcase
    if (g != G_NONE) m_busy[m_rd[2:0]] = 1'b0;
    if (issue_valid) m_busy[issue_rd] = 1'b1;
    #1;
    check("WE_R",     WE_R,     m_we);
    check("WrReg_Rd", WrReg_Rd, m_rd);
    check("InData_R", InData_R, m_data);
    check("busy",     busy,     m_busy);
    @(negedge clk);
  endtask

  logic [3:0] contention_rd [4];

  initial begin
    contention_rd[0] = 4'd1; contention_rd[1] = 4'd2;
    contention_rd[2] = 4'd1; contention_rd[3] = 4'd2;
    model_reset();

    // Reset values, and readies stay low while reset is held even with valids high.
    #2 rst_n = 1'b0;
    #1;
    check("rst_we",   WE_R, 1'b0);
    check("rst_rd",   WrReg_Rd, 4'd0);
    check("rst_data", InData_R, 16'h0);
    check("rst_busy", busy, 8'h00);
    pc_valid = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    check("rst_pc_ready",  pc_ready,  1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: ALU, MEM, ALU, MEM with back-to-back writes.
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_we", WE_R, 1'b1);
      check("rr_rd", WrReg_Rd, contention_rd[i]);
    end

    // PC beats both; arbiter preference is left where it was (ALU next).
    pc_valid = 1'b1; pc_data = 16'h0040;
    step();
    check("pc_rd",   WrReg_Rd, 4'd7);
    check("pc_data", InData_R, 16'h0040);
    pc_valid = 1'b0;
    #1 check("pc_keeps_pref", alu_ready, 1'b1);
    step();
    clear_inputs();

    // Scoreboard set, hazard, then clear by a load write.
    issue_valid = 1'b1; issue_rd = 3'd5;
    step();
    issue_valid = 1'b0; rs_a = 3'd5;
    #1 check("haz5_set", hazard_a, 1'b1);
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'hBEEF;
    step();
    mem_valid = 1'b0;
    #1;
    check("busy5_clr", busy[5], 1'b0);
    check("haz5_clr",  hazard_a, 1'b0);
    check("mem5_data", InData_R, 16'hBEEF);

    // Set and clear of R4 on the same edge: set wins.
    issue_valid = 1'b1; issue_rd = 3'd4;
    alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 16'h0444;
    step();
    check("coll_busy4", busy[4], 1'b1);
    check("coll_we",    WE_R, 1'b1);
    check("coll_rd",    WrReg_Rd, 4'd4);
    clear_inputs();

    // Idle after a write holds address and data with WE_R low.
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 16'h00AA;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_we",   WE_R, 1'b0);
      check("idle_rd",   WrReg_Rd, 4'd6);
      check("idle_data", InData_R, 16'h00AA);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pc_valid    = ($urandom_range(3) == 0);
      pc_data     = DATA_W'($urandom);
      alu_valid   = $urandom_range(1);
      alu_rd      = 3'($urandom);
      alu_data    = DATA_W'($urandom);
      mem_valid   = $urandom_range(1);
      mem_rd      = 3'($urandom);
      mem_data    = DATA_W'($urandom);
      issue_valid = $urandom_range(1);
      issue_rd    = 3'($urandom);
      rs_a        = 3'($urandom);
      rs_b        = 3'($urandom);
      step();
    end
    clear_inputs();

    // Reset mid-stream discards the pending write of R3.
    issue_valid = 1'b1; issue_rd = 3'd5;
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
    @(posedge clk);
    #2;
    check("mid_we_pre", WE_R, 1'b1);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("mid_we",   WE_R, 1'b0);
    check("mid_busy", busy, 8'h00);
    check("mid_rd",   WrReg_Rd, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_we", WE_R, 1'b0);
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h5A5A;
    step();
    check("first_xfer", WE_R, 1'b1);
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
